mem_sequencer: RTL and testbench

Multi-cycle sequencer for the PC/SP/memory datapath. On each `start` it fetches an instruction into the instruction register and advances PC. It then performs the requested memory-class operation (load, store, push, pop, jump), driving the datapath's write strobes and source/destination selects. Accesses to the memory-mapped I/O address use a valid/ready handshake with a timeout; every other operation has a fixed cycle count. It sits between the main control unit and the PC/SP/memory block and is the only driver of that block's control inputs.

---
 rtl/mem_seq_pkg.sv | 58 +++++
 rtl/io_wait_timer.sv | 36 +++
 rtl/mem_sequencer.sv | 179 +++++++++++++++++
 tb/tb_mem_sequencer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the PC/SP/memory sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, operation-class codes, datapath select encodings
// and a helper that folds the unused op codes onto NONE.
package mem_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_SP_DEC,
    S_MEM,
    S_SP_INC,
    S_PC_LOAD,
    S_IO_RD,
    S_IO_WR,
    S_DONE
  } state_t;

  // Operation classes presented on op
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_PUSH  = 3'd3;
  localparam logic [2:0] OP_POP   = 3'd4;
  localparam logic [2:0] OP_JUMP  = 3'd5;

  // MemSrc: memory address source
  localparam logic [1:0] ADDR_PC  = 2'd0;
  localparam logic [1:0] ADDR_SP  = 2'd1;
  localparam logic [1:0] ADDR_IMM = 2'd2;

  // MemDst: memory data destination
  localparam logic [2:0] DST_MARY    = 3'd0;
  localparam logic [2:0] DST_SHELLEY = 3'd1;
  localparam logic [2:0] DST_RA      = 3'd2;

  // PCSrc: next-PC source
  localparam logic [2:0] PC_INC  = 3'd0;
  localparam logic [2:0] PC_IMM  = 3'd1;
  localparam logic [2:0] PC_SE   = 3'd2;
  localparam logic [2:0] PC_RA   = 3'd3;
  localparam logic [2:0] PC_MARY = 3'd4;
  localparam logic [2:0] PC_COMP = 3'd5;

  // SPSrc: next-SP source
  localparam logic [1:0] SP_HOLD = 2'd0;
  localparam logic [1:0] SP_DEC  = 2'd1;
  localparam logic [1:0] SP_INC  = 2'd2;

  // Codes 6 and 7 are reserved and behave exactly like NONE.
  function automatic logic [2:0] norm_op(input logic [2:0] op_in);
    return (op_in > OP_JUMP) ? OP_NONE : op_in;
  endfunction

endpackage

// File: rtl/io_wait_timer.sv
// Wait-cycle counter for memory-mapped I/O handshakes.
// Latency: count updates one cycle after i_clr/i_en; o_expired is combinational from the count.
// Backpressure: none; saturates at IO_TIMEOUT so it never wraps while held.
//
// Ports:
//   i_clock, i_reset (async active-low)
//   i_clr     - synchronous clear to zero (wins over i_en)
//   i_en      - count one waiting cycle
//   o_expired - count has reached IO_TIMEOUT
module io_wait_timer #(
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam logic [15:0] LIMIT = 16'(IO_TIMEOUT);

  logic [15:0] r_count;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && (r_count != LIMIT)) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/mem_sequencer.sv
// Multi-cycle sequencer driving the PC/SP/memory datapath: fetch, then one memory-class op.
// Latency start->done: NONE 3, LOAD/STORE/JUMP 4, PUSH/POP 5, I/O 4 + wait cycles (max 4 + IO_TIMEOUT).
// Backpressure: start ignored unless idle; I/O waits on io_in_valid/io_out_ready, bounded by timeout.
//
// Ports:
//   clock, reset (async active-low)
//   start, op[2:0], ze_imm[15:0]             - command from the main control unit
//   io_in_valid, io_out_ready                - I/O handshake inputs
//   PCWrite, SPWrite, InstWrite, MemWrite    - datapath write strobes
//   MemSrc[1:0], MemDst[2:0], PCSrc[2:0], SPSrc[1:0] - datapath selects
//   io_in_ready, io_out_valid                - I/O handshake outputs
//   busy, done, io_err                       - status (io_err sticky until next start)
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter logic [15:0] IO_ADDR    = 16'd255,
  parameter int unsigned IO_TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] ze_imm,
  input  logic        io_in_valid,
  input  logic        io_out_ready,
  output logic        PCWrite,
  output logic        SPWrite,
  output logic        InstWrite,
  output logic        MemWrite,
  output logic [1:0]  MemSrc,
  output logic [2:0]  MemDst,
  output logic [2:0]  PCSrc,
  output logic [1:0]  SPSrc,
  output logic        io_in_ready,
  output logic        io_out_valid,
  output logic        busy,
  output logic        done,
  output logic        io_err
);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_op;
  logic       r_io_err;

  logic [2:0] w_op_dec;
  logic       w_is_io;
  logic       w_expired;
  logic       w_tmr_en;
  logic       w_tmr_clr;
  logic       w_timeout;

  assign w_op_dec = norm_op(op);
  assign w_is_io  = (ze_imm == IO_ADDR);

  // A cycle in an I/O state without the partner's handshake is a wait cycle.
  assign w_tmr_en  = ((r_state == S_IO_RD) && !io_in_valid) ||
                     ((r_state == S_IO_WR) && !io_out_ready);
  // DECODE always precedes an I/O state, so clearing there gives a fresh count on entry.
  assign w_tmr_clr = (r_state == S_DECODE);
  // A handshake in the expiry cycle takes priority, so only a handshake-less expiry is an error.
  assign w_timeout = w_tmr_en && w_expired;

  io_wait_timer #(
    .IO_TIMEOUT(IO_TIMEOUT)
  ) u_io_wait_timer (
    .i_clock   (clock),
    .i_reset   (reset),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_op     <= OP_NONE;
      r_io_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= w_op_dec;
      end
      if ((r_state == S_IDLE) && start) begin
        r_io_err <= 1'b0;
      end else if (w_timeout) begin
        r_io_err <= 1'b1;
      end
    end
  end

  // Next state and Moore outputs decoded from r_state and r_op.
  always_comb begin
    w_next       = r_state;
    PCWrite      = 1'b0;
    SPWrite      = 1'b0;
    InstWrite    = 1'b0;
    MemWrite     = 1'b0;
    MemSrc       = ADDR_PC;
    MemDst       = DST_MARY;
    PCSrc        = PC_INC;
    SPSrc        = SP_HOLD;
    io_in_ready  = 1'b0;
    io_out_valid = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = S_FETCH;
        end
      end
      S_FETCH: begin
        MemSrc    = ADDR_PC;
        InstWrite = 1'b1;
        PCWrite   = 1'b1;
        PCSrc     = PC_INC;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        // r_op is not loaded until the end of this cycle, so branch on the live op.
        case (w_op_dec)
          OP_JUMP:  w_next = S_PC_LOAD;
          OP_LOAD:  w_next = w_is_io ? S_IO_RD : S_MEM;
          OP_STORE: w_next = w_is_io ? S_IO_WR : S_MEM;
          OP_PUSH:  w_next = S_SP_DEC;
          OP_POP:   w_next = S_MEM;
          default:  w_next = S_DONE;
        endcase
      end
      S_SP_DEC: begin
        SPWrite = 1'b1;
        SPSrc   = SP_DEC;
        w_next  = S_MEM;
      end
      S_MEM: begin
        MemSrc   = ((r_op == OP_PUSH) || (r_op == OP_POP)) ? ADDR_SP : ADDR_IMM;
        MemWrite = (r_op == OP_STORE) || (r_op == OP_PUSH);
        MemDst   = DST_MARY;
        w_next   = (r_op == OP_POP) ? S_SP_INC : S_DONE;
      end
      S_SP_INC: begin
        SPWrite = 1'b1;
        SPSrc   = SP_INC;
        w_next  = S_DONE;
      end
      S_PC_LOAD: begin
        PCWrite = 1'b1;
        PCSrc   = PC_IMM;
        w_next  = S_DONE;
      end
      S_IO_RD: begin
        MemSrc      = ADDR_IMM;
        io_in_ready = 1'b1;
        if (io_in_valid || w_expired) begin
          w_next = S_DONE;
        end
      end
      S_IO_WR: begin
        MemSrc       = ADDR_IMM;
        MemWrite     = 1'b1;
        io_out_valid = 1'b1;
        if (io_out_ready || w_expired) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign io_err = r_io_err;

endmodule

// File: tb/tb_mem_sequencer.sv
// Self-checking bench for mem_sequencer: two instances (IO_TIMEOUT 255 and 4) share stimulus.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] ze_imm = 16'd0;
  logic        io_in_valid = 1'b0;
  logic        io_out_ready = 1'b0;

  logic [1:0] PCWrite, SPWrite, InstWrite, MemWrite;
  logic [1:0] io_in_ready, io_out_valid, busy, done, io_err;
  logic [1:0] MemSrc [2];
  logic [2:0] MemDst [2];
  logic [2:0] PCSrc  [2];
  logic [1:0] SPSrc  [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int start_cyc = 0;
  int meas_lat [2];
  int cnt_mw [2];
  int cnt_ir [2];
  int cnt_ov [2];
  int cnt_iw [2];
  int cnt_pcw [2];
  int cnt_spw [2];
  logic err_m [2];
  logic [18:0] q0 [$];
  logic [18:0] q1 [$];

  localparam int PH_IDLE = 0, PH_FETCH = 1, PH_DECODE = 2, PH_SPDEC = 3, PH_MEM = 4;
  localparam int PH_SPINC = 5, PH_PCLD = 6, PH_IORD = 7, PH_IOWR = 8, PH_DONE = 9;

  mem_sequencer #(.IO_ADDR(16'd255), .IO_TIMEOUT(255)) u_dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .ze_imm(ze_imm),
    .io_in_valid(io_in_valid), .io_out_ready(io_out_ready),
    .PCWrite(PCWrite[0]), .SPWrite(SPWrite[0]), .InstWrite(InstWrite[0]), .MemWrite(MemWrite[0]),
    .MemSrc(MemSrc[0]), .MemDst(MemDst[0]), .PCSrc(PCSrc[0]), .SPSrc(SPSrc[0]),
    .io_in_ready(io_in_ready[0]), .io_out_valid(io_out_valid[0]),
    .busy(busy[0]), .done(done[0]), .io_err(io_err[0])
  );

  mem_sequencer #(.IO_ADDR(16'd255), .IO_TIMEOUT(4)) u_dut4 (
    .clock(clock), .reset(reset), .start(start), .op(op), .ze_imm(ze_imm),
    .io_in_valid(io_in_valid), .io_out_ready(io_out_ready),
    .PCWrite(PCWrite[1]), .SPWrite(SPWrite[1]), .InstWrite(InstWrite[1]), .MemWrite(MemWrite[1]),
    .MemSrc(MemSrc[1]), .MemDst(MemDst[1]), .PCSrc(PCSrc[1]), .SPSrc(SPSrc[1]),
    .io_in_ready(io_in_ready[1]), .io_out_valid(io_out_valid[1]),
    .busy(busy[1]), .done(done[1]), .io_err(io_err[1])
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [18:0] actual(input int d);
    return {PCWrite[d], SPWrite[d], InstWrite[d], MemWrite[d], MemSrc[d], MemDst[d],
            PCSrc[d], SPSrc[d], io_in_ready[d], io_out_valid[d], busy[d], done[d], io_err[d]};
  endfunction

  // Output table per phase, written straight from the datapath control rules.
  function automatic logic [18:0] expv(input int ph, input int opc, input logic err);
    logic pcw, spw, iw, mw, ir, ov, bsy, dn;
    logic [1:0] ms, sps;
    logic [2:0] md, pcs;
    pcw = 0; spw = 0; iw = 0; mw = 0; ir = 0; ov = 0; dn = 0;
    ms = 0; sps = 0; md = 0; pcs = 0;
    bsy = (ph != PH_IDLE);
    case (ph)
      PH_FETCH: begin iw = 1; pcw = 1; end                        // ADDR_PC, PC_INC
      PH_SPDEC: begin spw = 1; sps = 2'd1; end
      PH_MEM:   begin
        ms = (opc == 3 || opc == 4) ? 2'd1 : 2'd2;
        mw = (opc == 2 || opc == 3);
      end
      PH_SPINC: begin spw = 1; sps = 2'd2; end
      PH_PCLD:  begin pcw = 1; pcs = 3'd1; end
      PH_IORD:  begin ms = 2'd2; ir = 1; end
      PH_IOWR:  begin ms = 2'd2; ov = 1; mw = 1; end
      PH_DONE:  dn = 1;
      default: ;
    endcase
    return {pcw, spw, iw, mw, ms, md, pcs, sps, ir, ov, bsy, dn, err};
  endfunction

  task automatic push_exp(input int d, input logic [18:0] v);
    if (d == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model queues.
  always @(negedge clock) begin
    logic [18:0] e;
    logic [18:0] a;
    for (int d = 0; d < 2; d++) begin
      if (d == 0 && q0.size() > 0) e = q0.pop_front();
      else if (d == 1 && q1.size() > 0) e = q1.pop_front();
      else e = expv(PH_IDLE, 0, err_m[d]);
      a = actual(d);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL outputs dut%0d cyc=%0d act=%b exp=%b", d, cyc - start_cyc, a, e);
      end
      if (done[d] && meas_lat[d] < 0) meas_lat[d] = cyc - start_cyc;
      cnt_mw[d]  += int'(MemWrite[d]);
      cnt_ir[d]  += int'(io_in_ready[d]);
      cnt_ov[d]  += int'(io_out_valid[d]);
      cnt_iw[d]  += int'(InstWrite[d]);
      cnt_pcw[d] += int'(PCWrite[d]);
      cnt_spw[d] += int'(SPWrite[d]);
    end
  end

  // Issue one instruction at posedge+1. w = I/O cycle index at which the handshake
  // rises and stays high (-1: never). abort_at > 0 pulses reset in that cycle.
  task automatic launch(input int opc, input logic [15:0] imm, input int w,
                        input int abort_at, input int extra_start);
    int opn, n_io, tmo, lmax, len;
    bit is_io, to, hs;
    opn = (opc > 5) ? 0 : opc;
    is_io = (opn == 1 || opn == 2) && (imm == 16'd255);
    lmax = 0;
    for (int d = 0; d < 2; d++) begin
      tmo = (d == 0) ? 255 : 4;
      to = is_io && !(w >= 0 && w <= tmo);
      n_io = !is_io ? 0 : (to ? tmo + 1 : w + 1);
      push_exp(d, expv(PH_IDLE, opn, err_m[d]));
      push_exp(d, expv(PH_FETCH, opn, 1'b0));
      push_exp(d, expv(PH_DECODE, opn, 1'b0));
      case (opn)
        1, 2: begin
          if (is_io) begin
            for (int k = 0; k < n_io; k++) push_exp(d, expv((opn == 1) ? PH_IORD : PH_IOWR, opn, 1'b0));
          end else begin
            push_exp(d, expv(PH_MEM, opn, 1'b0));
          end
        end
        3: begin push_exp(d, expv(PH_SPDEC, opn, 1'b0)); push_exp(d, expv(PH_MEM, opn, 1'b0)); end
        4: begin push_exp(d, expv(PH_MEM, opn, 1'b0)); push_exp(d, expv(PH_SPINC, opn, 1'b0)); end
        5: push_exp(d, expv(PH_PCLD, opn, 1'b0));
        default: ;
      endcase
      push_exp(d, expv(PH_DONE, opn, to));
      err_m[d] = to;
      len = ((d == 0) ? q0.size() : q1.size()) - 1;
      if (len > lmax) lmax = len;
      meas_lat[d] = -1;
      cnt_mw[d] = 0; cnt_ir[d] = 0; cnt_ov[d] = 0;
      cnt_iw[d] = 0; cnt_pcw[d] = 0; cnt_spw[d] = 0;
    end
    start_cyc = cyc;
    start = 1'b1;
    op = 3'(opc);
    ze_imm = imm;
    for (int c = 1; c <= lmax; c++) begin
      @(posedge clock); #1;
      start = (c == extra_start);
      if (c == abort_at) begin
        chk("pre_abort_io_out_valid", int'(io_out_valid[0]), 1);
        #2 reset = 1'b0;
        q0.delete(); q1.delete();
        err_m[0] = 1'b0; err_m[1] = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
          chk("abort_io_out_valid", int'(io_out_valid[d]), 0);
          chk("abort_busy", int'(busy[d]), 0);
          chk("abort_memwrite", int'(MemWrite[d]), 0);
        end
        @(posedge clock); #1;
        reset = 1'b1;
        start = 1'b0; io_in_valid = 1'b0; io_out_ready = 1'b0;
        return;
      end
      hs = is_io && (w >= 0) && (c >= 3 + w);
      io_in_valid  = hs && (opn == 1);
      io_out_ready = hs && (opn == 2);
    end
    @(posedge clock); #1;
    start = 1'b0; io_in_valid = 1'b0; io_out_ready = 1'b0;
  endtask

  initial begin
    err_m[0] = 1'b0; err_m[1] = 1'b0;
    for (int d = 0; d < 2; d++) meas_lat[d] = -1;
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outputs_dut0", int'(actual(0)), 0);
    chk("reset_outputs_dut4", int'(actual(1)), 0);
    reset = 1'b1;
    @(posedge clock); #1;

    launch(0, 16'h0000, -1, 0, 0);               // NONE
    chk("lat_none", meas_lat[0], 3);
    chk("none_instwrite_cycles", cnt_iw[0], 1);
    chk("none_pcwrite_cycles", cnt_pcw[0], 1);

    launch(2, 16'h0010, -1, 0, 0);               // STORE to plain memory
    chk("lat_store_mem", meas_lat[0], 4);
    chk("store_memwrite_cycles", cnt_mw[0], 1);
    chk("store_io_out_valid_cycles", cnt_ov[0], 0);

    launch(3, 16'h0020, -1, 0, 0);               // PUSH then POP back to back
    chk("lat_push", meas_lat[0], 5);
    chk("push_spwrite_cycles", cnt_spw[0], 1);
    launch(4, 16'h0020, -1, 0, 0);
    chk("lat_pop", meas_lat[0], 5);
    chk("pop_spwrite_cycles", cnt_spw[0], 1);

    launch(1, 16'd255, 7, 0, 0);                 // I/O read after 7 waits
    chk("lat_io_load_w7", meas_lat[0], 11);
    chk("io_load_ready_cycles", cnt_ir[0], 8);
    chk("io_load_err", int'(io_err[0]), 0);
    chk("lat_io_load_w7_t4", meas_lat[1], 8);
    chk("io_load_err_t4", int'(io_err[1]), 1);

    launch(1, 16'd255, 4, 0, 0);                 // handshake in the expiry cycle
    chk("lat_io_load_w4_t4", meas_lat[1], 8);
    chk("io_load_expiry_hs_err_t4", int'(io_err[1]), 0);

    launch(2, 16'd255, -1, 0, 0);                // I/O write, sink never ready
    chk("lat_io_store_timeout_t4", meas_lat[1], 8);
    chk("io_store_timeout_valid_t4", cnt_ov[1], 5);
    chk("io_store_timeout_err_t4", int'(io_err[1]), 1);
    chk("lat_io_store_timeout", meas_lat[0], 259);
    chk("io_store_timeout_err", int'(io_err[0]), 1);

    launch(0, 16'h0000, -1, 0, 0);               // next start clears io_err
    chk("io_err_cleared_t4", int'(io_err[1]), 0);
    chk("io_err_cleared", int'(io_err[0]), 0);

    launch(5, 16'h1234, -1, 0, 2);               // JUMP with a start pulse while busy
    chk("lat_jump", meas_lat[0], 4);
    chk("jump_pcwrite_cycles", cnt_pcw[0], 2);

    launch(6, 16'h0000, -1, 0, 0);               // reserved op acts as NONE
    chk("lat_op6", meas_lat[0], 3);

    launch(2, 16'd255, 0, 0, 0);                 // sink ready on first I/O cycle
    chk("lat_io_store_w0", meas_lat[0], 4);
    chk("lat_io_store_w0_t4", meas_lat[1], 4);

    launch(2, 16'd255, -1, 5, 0);                // reset in the middle of IO_WR
    launch(1, 16'h0040, -1, 0, 0);
    chk("lat_load_after_abort", meas_lat[0], 4);

    repeat (3) @(posedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
